// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundle of all handshake and memory-bus signals around mem_port_arbiter.
//   Fetch port   : i_req, i_addr          -> arbiter ; i_ack, i_rdata -> fetch
//   Data port    : d_req, d_we, d_addr,
//                  d_wdata                -> arbiter ; d_ack, d_rdata -> mem stage
//   Memory port  : mem_en, mem_we, mem_addr, mem_wdata -> memory ; mem_rdata -> arbiter
//   Status       : gnt_d (in-flight transaction belongs to D)
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding requesters and memory model
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              gnt_d;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, gnt_d
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata, gnt_d
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported synchronous memory between the instruction-fetch
// requester (I, read-only) and the data-access requester (D). One transaction
// at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE -> IDLE.
// D wins when both request, unless the optional anti-starvation guard is on.
//
// Ports:
//   clk    - clock, all state changes on posedge
//   rst_n  - asynchronous active-low reset
//   bus    - mem_port_arbiter_if.slave (fetch port, data port, memory port,
//            gnt_d status)
// Parameters:
//   MEM_LAT     - memory read latency in cycles (1..15)
//   MAX_DSTREAK - consecutive D grants allowed while I waits (1..15)
// Configuration macro:
//   ARB_FAIRNESS_EN - when defined, after MAX_DSTREAK D grants made while I
//                     was pending, the next contended grant goes to I.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int MEM_LAT     = 1,
   parameter int MAX_DSTREAK = 4
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arbStateT;

   localparam logic [3:0] LAT = 4'(MEM_LAT);

   arbStateT   state;
   logic [3:0] waitCnt;
   logic       ownerD;     // in-flight transaction belongs to D
   logic       latchedWe;  // in-flight transaction is a D write
   logic       pickD;      // arbitration result for the current IDLE cycle

`ifdef ARB_FAIRNESS_EN
   localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
   logic [3:0] dStreak;

   // Once D has won STREAK_MAX contended grants, a contended cycle goes to I.
   assign pickD = bus.d_req && !(bus.i_req && (dStreak == STREAK_MAX));
`else
   assign pickD = bus.d_req;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the whole datapath is reset, not just control, because every
      // output (including the address/data/rdata holding registers) must read
      // 0 out of reset and the abandoned access must vanish at once.
      if (!rst_n) begin
         state         <= IDLE;
         waitCnt       <= '0;
         ownerD        <= 1'b0;
         latchedWe     <= 1'b0;
         bus.i_ack     <= 1'b0;
         bus.d_ack     <= 1'b0;
         bus.i_rdata   <= '0;
         bus.d_rdata   <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.gnt_d     <= 1'b0;
`ifdef ARB_FAIRNESS_EN
         dStreak       <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout; the strobes below get a
         // default of 0 so each one is a single-cycle pulse unless re-asserted.
         bus.i_ack  <= 1'b0;
         bus.d_ack  <= 1'b0;
         bus.mem_en <= 1'b0;
         bus.mem_we <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.i_req || bus.d_req) begin
                  ownerD     <= pickD;
                  bus.gnt_d  <= pickD;
                  bus.mem_en <= 1'b1;
                  if (pickD) begin
                     bus.mem_addr  <= bus.d_addr;
                     bus.mem_wdata <= bus.d_wdata;
                     bus.mem_we    <= bus.d_we;
                     latchedWe     <= bus.d_we;
                  end else begin
                     // Fetch is read-only; write data register keeps its value.
                     bus.mem_addr  <= bus.i_addr;
                     latchedWe     <= 1'b0;
                  end
`ifdef ARB_FAIRNESS_EN
                  if (!pickD)
                     dStreak <= '0;
                  else if (bus.i_req)
                     dStreak <= dStreak + 4'd1;
`endif
                  state <= ISSUE;
               end
            end

            ISSUE: begin
               waitCnt <= LAT;
               state   <= WAIT;
            end

            WAIT: begin
               waitCnt <= waitCnt - 4'd1;
               // Count of 1 marks the cycle in which mem_rdata is valid.
               if (waitCnt == 4'd1) begin
                  if (!ownerD)
                     bus.i_rdata <= bus.mem_rdata;
                  else if (!latchedWe)
                     bus.d_rdata <= bus.mem_rdata;
                  bus.i_ack <= !ownerD;
                  bus.d_ack <= ownerD;
                  state     <= DONE;
               end
            end

            DONE: begin
               bus.gnt_d <= 1'b0;
               state     <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported synchronous memory between the CPU's instruction-fetch requester (I) and data-access requester (D). Sits between the PC/fetch stage, the memory stage and the unified memory array. Runs one transaction at a time through a small FSM with a fixed-latency wait. Data accesses have priority, with an optional anti-starvation guard for fetch.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles (1..15)
- MAX_DSTREAK, 4, consecutive D grants allowed while I is pending (1..15; used only with fairness)

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle pulse: fetch done, i_rdata valid
- i_rdata  out  DATA_W  fetched word, held until next I completion
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle pulse: data access done
- d_rdata  out  DATA_W  read word, held until next D read completion
- mem_en  out  1  memory access strobe, exactly one cycle per transaction
- mem_we  out  1  write strobe, only with mem_en
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
- gnt_d  out  1  1 while the in-flight transaction belongs to D

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample requests at posedge.
  - Neither request: stay in IDLE.
  - Any request: latch owner, address, we and wdata; go to ISSUE.
- ISSUE: mem_en=1, and mem_we=d_we latched (0 for I). Load wait counter with MEM_LAT; go to WAIT.
- WAIT: decrement the counter. On the cycle it reaches 1, capture mem_rdata into the owner's rdata register (D writes capture nothing), then go to DONE.
- DONE: assert the owner's ack; go to IDLE unconditionally.
- Arbitration in IDLE:
  - Only one request: grant it.
  - Both requests: grant D, except as noted under Configuration.
- Requester rules:
  - Inputs must be held stable from req rise until ack.
  - A req still high in the cycle after ack is a new transaction.
- I port is read-only; mem_we is never 1 for an I transaction.
- mem_addr and mem_wdata hold latched values from ISSUE until the next ISSUE.

## Timing
- Request high in IDLE cycle r:
  - ISSUE at r+1.
  - mem_rdata sampled at the end of r+1+MEM_LAT.
  - ack at r+2+MEM_LAT. With MEM_LAT=1, ack at r+3.
- Occupancy is MEM_LAT+3 cycles per transaction. Back-to-back requests from one port complete every MEM_LAT+3 cycles.
- Reset values:
  - State IDLE.
  - All outputs 0: i_ack, d_ack, mem_en, mem_we, gnt_d, mem_addr, mem_wdata, i_rdata, d_rdata.
  - Wait counter and D-streak counter 0.
- Reset mid-transaction: the in-flight access is abandoned immediately, with no ack and mem_en dropped asynchronously. Requesters must re-request after rst_n rises.
- rst_n deassertion is synchronous-safe: the first sample is on the first posedge with rst_n=1.
- A request arriving while not in IDLE waits. It is never lost or merged.

## Configuration
- ARB_FAIRNESS_EN defined:
  - A 4-bit D-streak counter increments on each D grant made while i_req=1.
  - It resets to 0 on any I grant.
  - When the counter equals MAX_DSTREAK and both requests are high in IDLE, I is granted.
- ARB_FAIRNESS_EN undefined:
  - Strict D priority; no counter exists.
  - I can starve while d_req stays high.

## Test plan
- Single fetch, MEM_LAT=1, i_req at cycle 5, addr 0x10, memory word 0xDEADBEEF:
  - mem_en=1, mem_we=0 at cycle 6; i_ack and i_rdata=0xDEADBEEF at cycle 8; gnt_d=0.
- Data write, d_we=1, addr 0x40, wdata 0x12345678:
  - mem_en=mem_we=1 for exactly one cycle, mem_addr=0x40; d_ack 3 cycles after request; d_rdata unchanged.
- Simultaneous i_req and d_req with fairness off:
  - D completes first (d_ack at r+3); I issues at r+5; i_ack at r+7.
- Fairness on, MAX_DSTREAK=4, both requests held continuously:
  - Grant order D,D,D,D,I,D,D,D,D,I; counter returns to 0 after each I grant.
- MEM_LAT=3 read:
  - ack exactly 5 cycles after request; mem_rdata changes outside the sample cycle do not affect the captured data.
- rst_n low during WAIT:
  - All outputs 0 immediately; no ack after release; a fresh request completes normally.
